// File: rtl/aibcr3aux_rxlvshift_filt.sv
// ---------------------------------------------------------------------------
// aibcr3aux_rxlvshift_filt
//
// Receive-direction aux level shifter. Carries one slow control/status signal
// from the AIB aux IO supply domain into the core supply domain: clamps it low
// unless both supplies are good, synchronizes it into clk, filters out pulses
// shorter than FILT_CYCLES, and qualifies the result with a power-up settle
// sequencer (OFF -> WAIT -> ACTIVE).
//
// Parameters:
//   SYNC_STAGES   synchronizer depth (2..4)
//   FILT_CYCLES   consecutive differing cycles needed before out changes (1..15)
//   PWRUP_CYCLES  settle cycles in WAIT before out becomes valid (1..255)
//
// Ports:
//   clk             core-domain clock
//   rst             asynchronous active-high reset
//   vccl_aibcr3aux  core supply indicator (1 = powered)
//   vcc_aibcr3aux   IO supply indicator (1 = powered)
//   vssl_aibcr3aux  ground, not tracked functionally
//   in              IO-domain signal, asynchronous to clk
//   out             filtered core-domain version of in
//   out_vld         1 while in ACTIVE
//   glitch_det      one-cycle pulse when a short pulse is rejected
// ---------------------------------------------------------------------------
module aibcr3aux_rxlvshift_filt #(
    parameter int unsigned SYNC_STAGES  = 2,
    parameter int unsigned FILT_CYCLES  = 4,
    parameter int unsigned PWRUP_CYCLES = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic vccl_aibcr3aux,
    input  logic vcc_aibcr3aux,
    input  logic vssl_aibcr3aux,
    input  logic in,
    output logic out,
    output logic out_vld,
    output logic glitch_det
);

    localparam logic [1:0] StOff    = 2'd0;
    localparam logic [1:0] StWait   = 2'd1;
    localparam logic [1:0] StActive = 2'd2;

    localparam logic [3:0] FiltLast  = 4'(FILT_CYCLES - 1);
    localparam logic [7:0] PwrupLast = 8'(PWRUP_CYCLES - 1);

    logic                   pwr_good;
    logic                   in_ls;
    logic                   sync;
    logic                   unused_vssl;

    logic [1:0]             state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d, sync_shift;
    logic [7:0]             scnt_q, scnt_d;
    logic [3:0]             fcnt_q, fcnt_d;
    logic                   out_q, out_d;
    logic                   glitch_q, glitch_d;

    // Only a solid 1 on both supplies counts as powered; X/Z is treated as off.
    assign pwr_good    = (vccl_aibcr3aux === 1'b1) && (vcc_aibcr3aux === 1'b1);
    assign in_ls       = pwr_good ? in : 1'b0;
    assign unused_vssl = vssl_aibcr3aux;

    assign sync_shift  = {sync_q[SYNC_STAGES-2:0], in_ls};
    assign sync        = sync_q[SYNC_STAGES-1];

    always_comb begin
        state_d  = state_q;
        sync_d   = '0;
        scnt_d   = scnt_q;
        fcnt_d   = fcnt_q;
        out_d    = out_q;
        glitch_d = 1'b0;

        if (!pwr_good) begin
            // Supply loss overrides everything, including a pending filter accept.
            state_d = StOff;
            scnt_d  = '0;
            fcnt_d  = '0;
            out_d   = 1'b0;
        end else begin
            unique case (state_q)
                StOff: begin
                    state_d = StWait;
                    scnt_d  = '0;
                    fcnt_d  = '0;
                    out_d   = 1'b0;
                end
                StWait: begin
                    sync_d = sync_shift;
                    fcnt_d = '0;
                    out_d  = 1'b0;
                    if (scnt_q == PwrupLast) begin
                        // Enter ACTIVE with the current synchronized value, unfiltered.
                        state_d = StActive;
                        scnt_d  = '0;
                        out_d   = sync;
                    end else begin
                        scnt_d = scnt_q + 8'd1;
                    end
                end
                StActive: begin
                    sync_d = sync_shift;
                    if (sync == out_q) begin
                        // A nonzero run that collapsed back means a rejected pulse.
                        glitch_d = (fcnt_q != 4'd0);
                        fcnt_d   = '0;
                    end else if (fcnt_q == FiltLast) begin
                        out_d  = sync;
                        fcnt_d = '0;
                    end else begin
                        fcnt_d = fcnt_q + 4'd1;
                    end
                end
                default: begin
                    state_d = StOff;
                    scnt_d  = '0;
                    fcnt_d  = '0;
                    out_d   = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StOff;
            sync_q   <= '0;
            scnt_q   <= '0;
            fcnt_q   <= '0;
            out_q    <= 1'b0;
            glitch_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            sync_q   <= sync_d;
            scnt_q   <= scnt_d;
            fcnt_q   <= fcnt_d;
            out_q    <= out_d;
            glitch_q <= glitch_d;
        end
    end

    assign out        = out_q;
    assign out_vld    = (state_q == StActive);
    assign glitch_det = glitch_q;

endmodule

// File: doc/aibcr3aux_rxlvshift_filt.md
# aibcr3aux_rxlvshift_filt

Receive-direction auxiliary level shifter: carries a single slow control or status signal from the AIB aux IO supply domain (vcc_aibcr3aux) down into the core supply domain (vccl_aibcr3aux). The block synchronizes the signal into the core clock, rejects glitches, and qualifies the output with a supply-tracking power-up sequencer. It is the inbound counterpart of the core-to-IO aux level shifter and sits in the aux channel between the IO-side receiver and core sideband logic.

## Interface
- SYNC_STAGES, 2: synchronizer depth; legal range 2..4.
- FILT_CYCLES, 4: consecutive stable cycles required before out changes; legal range 1..15.
- PWRUP_CYCLES, 8: settle cycles after both supplies are good before out is valid; legal range 1..255.
- clk  input  1  core-domain clock.
- rst  input  1  reset; asynchronous, active-high.
- vccl_aibcr3aux  input  1  core supply indicator; 1 = powered.
- vcc_aibcr3aux  input  1  IO supply indicator; 1 = powered.
- vssl_aibcr3aux  input  1  ground; not tracked functionally.
- in  input  1  IO-domain signal, asynchronous to clk.
- out  output  1  filtered, core-domain version of in.
- out_vld  output  1  1 when out is meaningful (state ACTIVE).
- glitch_det  output  1  one-cycle pulse when a pulse shorter than FILT_CYCLES is rejected.

## Operation
- pwr_good = (vccl_aibcr3aux === 1'b1) && (vcc_aibcr3aux === 1'b1). Any 0, X or Z on either supply counts as not good.
- Level-shift input: in_ls = pwr_good ? in : 1'b0 (IO side unpowered or core unpowered clamps low).
- Synchronizer: SYNC_STAGES-deep flop chain on in_ls; sync = last stage.
- FSM states: OFF, WAIT, ACTIVE.
  - OFF: out=0, out_vld=0, sync chain and counters cleared. pwr_good=1 -> WAIT.
  - WAIT: settle counter increments each cycle; sync chain runs; out=0, out_vld=0. When counter reaches PWRUP_CYCLES-1 -> ACTIVE, loading out <= sync directly (no filter).
  - ACTIVE: out_vld=1; filter operates. pwr_good=0 -> OFF.
  - pwr_good=0 in any state -> OFF on next edge; takes priority over every other transition.
- Filter (ACTIVE only): 4-bit counter fcnt. If sync == out, fcnt <= 0. If sync != out and fcnt == FILT_CYCLES-1, out <= sync, fcnt <= 0; else fcnt <= fcnt+1.
- glitch_det: registered; asserted for one cycle when in ACTIVE, fcnt != 0 and sync == out (pulse collapsed before acceptance). Never asserted outside ACTIVE.
- FILT_CYCLES=1: out follows sync with one cycle delay; glitch_det never fires.

## Timing
- Reset (rst=1): state=OFF, out=0, out_vld=0, glitch_det=0, sync chain=0, fcnt=0, settle counter=0. Asynchronous assertion, synchronous-effect deassertion.
- Power-up: pwr_good rises before edge 0 -> WAIT at edge 0; ACTIVE and out_vld=1 after edge PWRUP_CYCLES (default: 9 cycles after pwr_good seen, i.e., 1 + PWRUP_CYCLES).
- Data latency in ACTIVE: in change settled before edge 1 -> sync changes at edge SYNC_STAGES -> out changes at edge SYNC_STAGES+FILT_CYCLES (default 6).
- Pulses on sync lasting < FILT_CYCLES cycles never reach out; glitch_det pulses the cycle after sync returns.
- Supply drop: out and out_vld go 0 at the first clk edge with pwr_good=0; not combinational.
- Supply drop in WAIT restarts the full settle count on next power-good.
- Simultaneous supply drop and filter acceptance: OFF wins, out=0.

## Test plan
- Reset then both supplies 1, in=1 -> out_vld=0 for 9 cycles, then out_vld=1 and out=1 in the same cycle.
- ACTIVE, out=0, in 0->1 held -> out=1 exactly 6 cycles later, glitch_det stays 0.
- ACTIVE, out=0, in high for 2 cycles -> out stays 0; glitch_det=1 for exactly one cycle.
- ACTIVE, vcc_aibcr3aux 1->0 -> next edge out=0, out_vld=0; restore -> 9-cycle WAIT repeats, then out reflects in.
- vccl_aibcr3aux=X with vcc_aibcr3aux=1 -> state OFF, out=0, out_vld=0; rst asserted mid-WAIT -> all outputs 0 immediately, without waiting for a clock edge.
- FILT_CYCLES=1, SYNC_STAGES=3 -> in toggle reaches out in 4 cycles; 1-cycle pulses pass through.
